// File: rtl/bicubic_scan_ctrl.sv
// Scan sequencer for a single bicubic core producing a 2x upscaled frame.
// It issues clamped 4-tap column reads and tags each core output with its coordinates.
module bicubic_scan_ctrl #(
    parameter int DIM_W  = 11,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DIM_W-1:0] src_width_i,
    input  logic [DIM_W-1:0] src_height_i,
    input  logic             rows_avail_i,
    input  logic             hold_i,
    output logic             rd_en_o,
    output logic [DIM_W-1:0] rd_x_o,
    output logic [DIM_W-1:0] rd_y_o,
    output logic             h_phase_o,
    output logic             v_phase_o,
    output logic             out_valid_o,
    output logic [DIM_W:0]   out_x_o,
    output logic [DIM_W:0]   out_y_o,
    output logic             busy_o,
    output logic             done_o
);
    // Stage k of the token pipe holds a pixel launched at its first read cycle r, in cycle r+1+k.
    localparam int STAGES = RD_LAT + 4;

    typedef enum logic [1:0] {IDLE, WAIT, FETCH, DRAIN} state_e;

    state_e                     state_q, state_d;
    logic [DIM_W-1:0]           w_q, w_d, h_q, h_d;
    logic [DIM_W:0]             ox_q, ox_d, oy_q, oy_d;
    logic [1:0]                 tap_q, tap_d;
    logic                       done_q, done_d;
    logic                       h_ph_q, v_ph_q;
    logic                       launch;
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][DIM_W:0]   x_pipe, y_pipe;

    logic [DIM_W:0]   ox_max, oy_max;
    logic             last_x, last_y;
    logic [DIM_W+1:0] col_sum, col;
    logic [DIM_W-1:0] col_clamped;

    assign ox_max = {w_q, 1'b0} - 1'b1;
    assign oy_max = {h_q, 1'b0} - 1'b1;
    assign last_x = (ox_q == ox_max);
    assign last_y = (oy_q == oy_max);

    // col_sum = x + tap, so the wanted column is col_sum - 1; zero means the left border.
    assign col_sum = {2'b00, ox_q[DIM_W:1]} + {{DIM_W{1'b0}}, tap_q};
    assign col     = col_sum - 1'b1;

    always_comb begin
        col_clamped = col[DIM_W-1:0];
        if (col_sum == '0)
            col_clamped = '0;
        else if (col >= {2'b00, w_q})
            col_clamped = w_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        tap_d   = tap_q;
        done_d  = 1'b0;
        launch  = 1'b0;
        rd_en_o = 1'b0;
        rd_x_o  = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    w_d     = src_width_i;
                    h_d     = src_height_i;
                    ox_d    = '0;
                    oy_d    = '0;
                    tap_d   = '0;
                    state_d = (src_width_i == '0 || src_height_i == '0) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (rows_avail_i && !hold_i)
                    state_d = FETCH;
            end
            FETCH: begin
                rd_en_o = 1'b1;
                rd_x_o  = col_clamped;
                launch  = (tap_q == 2'd0);
                tap_d   = tap_q + 2'd1;
                if (tap_q == 2'd3) begin
                    if (last_x) begin
                        ox_d = '0;
                        oy_d = oy_q + 1'b1;
                    end else begin
                        ox_d = ox_q + 1'b1;
                    end
                    // Odd oy wrapping means the next row needs a new source row in the buffer.
                    if (last_x && last_y)
                        state_d = DRAIN;
                    else if (last_x && oy_q[0])
                        state_d = WAIT;
                    else if (hold_i || !rows_avail_i)
                        state_d = WAIT;
                end
            end
            DRAIN: begin
                // Only the exiting stage may still be valid; done follows its out_valid.
                if (!(|vld_pipe[STAGES-1:0])) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            w_q      <= '0;
            h_q      <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            tap_q    <= '0;
            done_q   <= 1'b0;
            h_ph_q   <= 1'b0;
            v_ph_q   <= 1'b0;
            vld_pipe <= '0;
            x_pipe   <= '0;
            y_pipe   <= '0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            h_q      <= h_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            tap_q    <= tap_d;
            done_q   <= done_d;
            vld_pipe <= {vld_pipe[STAGES-1:0], launch};
            x_pipe   <= {x_pipe[STAGES-1:0], ox_q};
            y_pipe   <= {y_pipe[STAGES-1:0], oy_q};
            if (vld_pipe[STAGES-2])
                h_ph_q <= x_pipe[STAGES-2][0];
            if (vld_pipe[STAGES-1])
                v_ph_q <= y_pipe[STAGES-1][0];
        end
    end

    assign rd_y_o      = oy_q[DIM_W:1];
    assign h_phase_o   = h_ph_q;
    assign v_phase_o   = v_ph_q;
    assign out_valid_o = vld_pipe[STAGES];
    assign out_x_o     = vld_pipe[STAGES] ? x_pipe[STAGES] : '0;
    assign out_y_o     = vld_pipe[STAGES] ? y_pipe[STAGES] : '0;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
endmodule

// File: tb/tb_bicubic_scan_ctrl.sv
// Directed bench for bicubic_scan_ctrl: clamp table, frame order/timing, stalls,
// degenerate sizes, ignored start and mid-frame reset.
module tb_bicubic_scan_ctrl;
    localparam int DW = 11;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, rows_avail = 1'b1, hold = 1'b0;
    logic [DW-1:0] src_w = '0, src_h = '0;
    logic          rd_en, h_phase, v_phase, out_valid, busy, done;
    logic [DW-1:0] rd_x, rd_y;
    logic [DW:0]   out_x, out_y;

    bicubic_scan_ctrl #(.DIM_W(DW), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start_i(start), .src_width_i(src_w), .src_height_i(src_h),
        .rows_avail_i(rows_avail), .hold_i(hold), .rd_en_o(rd_en), .rd_x_o(rd_x), .rd_y_o(rd_y),
        .h_phase_o(h_phase), .v_phase_o(v_phase), .out_valid_o(out_valid), .out_x_o(out_x),
        .out_y_o(out_y), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int x; int y; } rd_ev_t;
    typedef struct { int cyc; int x; int y; int vph; int hprev; } out_ev_t;
    typedef struct { int pix; int r0; int r1; int r2; int r3; int ry; } clamp_vec_t;

    rd_ev_t  rd_q[$];
    out_ev_t out_q[$];
    int      done_q[$];
    int      done_busy[$];
    rd_ev_t  re;
    out_ev_t oe;
    logic    prev_h = 1'b0;

    // Event recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (rd_en) begin
            re.cyc = cyc; re.x = int'(rd_x); re.y = int'(rd_y);
            rd_q.push_back(re);
        end
        if (out_valid) begin
            oe.cyc = cyc; oe.x = int'(out_x); oe.y = int'(out_y);
            oe.vph = int'(v_phase); oe.hprev = int'(prev_h);
            out_q.push_back(oe);
        end
        if (done) begin
            done_q.push_back(cyc);
            done_busy.push_back(int'(busy));
        end
        prev_h = h_phase;
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic clear_mon();
        rd_q.delete(); out_q.delete(); done_q.delete(); done_busy.delete();
    endtask

    task automatic start_frame(input int w, input int h, output int s);
        src_w = DW'(w); src_h = DW'(h); start = 1'b1; s = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done_q.size() == 0 && i < budget) begin tick(1); i++; end
        check("done_seen", (done_q.size() > 0) ? 1 : 0, 1);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_rd_x"}, int'(rd_x), 0);
        check({tag, "_rd_y"}, int'(rd_y), 0);
        check({tag, "_h_phase"}, int'(h_phase), 0);
        check({tag, "_v_phase"}, int'(v_phase), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_x"}, int'(out_x), 0);
        check({tag, "_out_y"}, int'(out_y), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // Whole-frame check: raster order, phases, clamped reads, timing.
    task automatic check_frame(input int w, input int h, input int s, input bit spaced);
        int ow, np, x, y, xs;
        ow = 2 * w; np = 4 * w * h;
        check("out_count", out_q.size(), np);
        check("rd_count", rd_q.size(), 4 * np);
        for (int p = 0; p < np && p < out_q.size(); p++) begin
            x = p % ow; y = p / ow;
            check("out_x", out_q[p].x, x);
            check("out_y", out_q[p].y, y);
            check("v_phase", out_q[p].vph, y & 1);
            check("h_phase_prev", out_q[p].hprev, x & 1);
            if (spaced && p > 0)
                check("out_spacing", out_q[p].cyc - out_q[p-1].cyc,
                      (x == 0 && (y % 2) == 0) ? 5 : 4);
        end
        for (int i = 0; i < 4 * np && i < rd_q.size(); i++) begin
            x = (i / 4) % ow; y = (i / 4) / ow;
            xs = x / 2 - 1 + (i % 4);
            if (xs < 0) xs = 0;
            if (xs > w - 1) xs = w - 1;
            check("rd_x", rd_q[i].x, xs);
            check("rd_y", rd_q[i].y, y / 2);
        end
        if (rd_q.size() > 0) check("first_rd_cyc", rd_q[0].cyc - s, 2);
        if (out_q.size() > 0) check("first_out_cyc", out_q[0].cyc - s, 8);
        check("done_count", done_q.size(), 1);
        if (done_q.size() > 0 && out_q.size() > 0) begin
            check("done_after_last", done_q[0] - out_q[out_q.size()-1].cyc, 1);
            check("busy_at_done", done_busy[0], 0);
        end
    endtask

    clamp_vec_t tbl[6];

    function automatic clamp_vec_t mk(input int pix, input int a, input int b,
                                      input int c, input int d, input int ry);
        clamp_vec_t v;
        v.pix = pix; v.r0 = a; v.r1 = b; v.r2 = c; v.r3 = d; v.ry = ry;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, h0, i;
        // W=4 clamp vectors by pixel index p = oy*8 + ox.
        tbl[0] = mk(0,  0, 0, 1, 2, 0);  // ox=0
        tbl[1] = mk(2,  0, 1, 2, 3, 0);  // ox=2
        tbl[2] = mk(7,  2, 3, 3, 3, 0);  // ox=7
        tbl[3] = mk(12, 1, 2, 3, 3, 0);  // ox=4, oy=1
        tbl[4] = mk(16, 0, 0, 1, 2, 1);  // ox=0, oy=2
        tbl[5] = mk(31, 2, 3, 3, 3, 1);  // ox=7, oy=3

        tick(3);
        chk_idle("reset");
        rst = 1'b0;
        tick(2);

        // Basic frame, with a start attempt while busy.
        clear_mon();
        start_frame(4, 2, s);
        tick(20);
        check("busy_mid_frame", int'(busy), 1);
        src_w = DW'(2); src_h = DW'(1); start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(600);
        tick(2);
        check_frame(4, 2, s, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (rd_q.size() >= 4 * tbl[k].pix + 4) begin
                check("tbl_rd_x0", rd_q[4*tbl[k].pix + 0].x, tbl[k].r0);
                check("tbl_rd_x1", rd_q[4*tbl[k].pix + 1].x, tbl[k].r1);
                check("tbl_rd_x2", rd_q[4*tbl[k].pix + 2].x, tbl[k].r2);
                check("tbl_rd_x3", rd_q[4*tbl[k].pix + 3].x, tbl[k].r3);
                check("tbl_rd_y", rd_q[4*tbl[k].pix].y, tbl[k].ry);
            end else begin
                check("tbl_rd_present", rd_q.size(), 4 * tbl[k].pix + 4);
            end
        end
        if (out_q.size() == 32)
            check("last_pixel_xy", out_q[31].x * 100 + out_q[31].y, 703);
        tick(30);
        check("busy_start_ignored_out", out_q.size(), 32);
        check("busy_start_ignored_done", done_q.size(), 1);

        // Degenerate 1x1 source.
        clear_mon();
        start_frame(1, 1, s);
        wait_done(200);
        tick(2);
        check_frame(1, 1, s, 1'b1);

        // Zero-size sources: no reads, done two cycles after start.
        clear_mon();
        start_frame(0, 3, s);
        wait_done(20);
        tick(2);
        check("w0_rd_count", rd_q.size(), 0);
        if (done_q.size() > 0) check("w0_done_cyc", done_q[0] - s, 2);
        if (done_busy.size() > 0) check("w0_busy_at_done", done_busy[0], 0);
        clear_mon();
        start_frame(2, 0, s);
        wait_done(20);
        tick(2);
        check("h0_rd_count", rd_q.size(), 0);
        if (done_q.size() > 0) check("h0_done_cyc", done_q[0] - s, 2);

        // Stalls: rows_avail low at the oy=2 boundary, hold during pixel 19.
        clear_mon();
        start_frame(4, 2, s);
        i = 0;
        while (rd_q.size() < 64 && i < 400) begin tick(1); i++; end
        check("stall_reach_row2", (rd_q.size() >= 64) ? 1 : 0, 1);
        d = cyc;
        rows_avail = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("no_rd_rows_stall", int'(rd_en), 0);
        end
        rows_avail = 1'b1;
        i = 0;
        while (rd_q.size() < 78 && i < 400) begin tick(1); i++; end
        check("stall_reach_px19", (rd_q.size() >= 78) ? 1 : 0, 1);
        h0 = cyc;
        hold = 1'b1;
        tick(3);
        hold = 1'b0;
        wait_done(600);
        tick(2);
        if (rd_q.size() > 80) begin
            check("rows_resume_cyc", rd_q[64].cyc - d, 11);
            check("px19_tap3_cyc", rd_q[79].cyc - h0, 2);
            check("hold_resume_cyc", rd_q[80].cyc - h0, 4);
        end
        check_frame(4, 2, s, 1'b0);

        // Reset at the 10th out_valid, then a fresh frame.
        clear_mon();
        start_frame(4, 2, s);
        i = 0;
        while (out_q.size() < 10 && i < 400) begin tick(1); i++; end
        check("reach_10th_out", out_q.size(), 10);
        rst = 1'b1;
        tick(1);
        chk_idle("midrst");
        tick(1);
        rst = 1'b0;
        tick(40);
        check("midrst_no_more_out", out_q.size(), 10);
        check("midrst_no_done", done_q.size(), 0);
        clear_mon();
        start_frame(4, 2, s);
        wait_done(600);
        tick(2);
        check_frame(4, 2, s, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
